ws_sequencer: RTL and testbench



---
 rtl/ws_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_ws_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_sequencer.sv
// ws_sequencer: issues the core inst/D_xmem stream for one weight-stationary tile per start.
// Optional drain watchdog enabled by defining SEQ_DRAIN_TIMEOUT_EN.
module ws_sequencer #(
    parameter int bw      = 4,
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int gap_cyc = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [10:0]       n_act,
    input  logic [10:0]       xmem_base,
    input  logic [10:0]       pmem_base,
    input  logic              s_valid,
    input  logic [row*bw-1:0] s_data,
    output logic              s_ready,
    input  logic              ofifo_valid,
    output logic [34:0]       inst,
    output logic [row*bw-1:0] D_xmem,
    output logic              busy,
    output logic              done,
    output logic              err
);
    // Both memories chip-disabled and write-disabled, no core action.
    localparam logic [34:0] idle_inst = 35'h1_800C_0000;
    localparam logic [11:0] col_w     = 12'(col);
    localparam logic [11:0] gap_w     = 12'(gap_cyc);
    localparam logic [10:0] col_a     = 11'(col);

    typedef enum logic [3:0] {
        S_IDLE, S_WR, S_KLD, S_KEX, S_GAP, S_ALD, S_EXE, S_DRN, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [11:0]       cnt_reg, cnt_next;
    logic [10:0]       n_act_reg, n_act_next;
    logic [10:0]       xbase_reg, xbase_next;
    logic [10:0]       pbase_reg, pbase_next;
    logic [10:0]       rd_cnt_reg, rd_cnt_next;
    logic [10:0]       wr_cnt_reg, wr_cnt_next;
    logic              pend_reg, pend_next;
    logic [34:0]       inst_reg, inst_next;
    logic [row*bw-1:0] dx_reg, dx_next;
    logic              s_ready_reg, s_ready_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [11:0]       n_ext;

`ifdef SEQ_DRAIN_TIMEOUT_EN
    logic              err_reg, err_next;
    logic [9:0]        to_cnt_reg, to_cnt_next;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign n_ext   = {1'b0, n_act_reg};
    assign inst    = inst_reg;
    assign D_xmem  = dx_reg;
    assign s_ready = s_ready_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        n_act_next   = n_act_reg;
        xbase_next   = xbase_reg;
        pbase_next   = pbase_reg;
        rd_cnt_next  = rd_cnt_reg;
        wr_cnt_next  = wr_cnt_reg;
        pend_next    = 1'b0;
        inst_next    = idle_inst;
        dx_next      = dx_reg;
        s_ready_next = s_ready_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
`ifdef SEQ_DRAIN_TIMEOUT_EN
        err_next     = err_reg;
        to_cnt_next  = to_cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    n_act_next  = n_act;
                    xbase_next  = xmem_base;
                    pbase_next  = pmem_base;
                    cnt_next    = 12'd0;
                    rd_cnt_next = 11'd0;
                    wr_cnt_next = 11'd0;
`ifdef SEQ_DRAIN_TIMEOUT_EN
                    err_next    = 1'b0;
                    to_cnt_next = 10'd0;
`endif
                    if (n_act == 11'd0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next   = S_WR;
                        busy_next    = 1'b1;
                        s_ready_next = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (s_valid && s_ready_reg) begin
                    inst_next[19]   = 1'b0;
                    inst_next[18]   = 1'b0;
                    inst_next[17:7] = xbase_reg + cnt_reg[10:0];
                    dx_next         = s_data;
                    if (cnt_reg == n_ext + col_w - 12'd1) begin
                        s_ready_next = 1'b0;
                        cnt_next     = 12'd0;
                        state_next   = S_KLD;
                    end else begin
                        cnt_next = cnt_reg + 12'd1;
                    end
                end
            end
            S_KLD: begin
                // l0_wr trails each read by one cycle to match the SRAM read latency.
                if (cnt_reg != col_w) begin
                    inst_next[19]   = 1'b0;
                    inst_next[17:7] = xbase_reg + cnt_reg[10:0];
                end
                if (cnt_reg != 12'd0)
                    inst_next[2] = 1'b1;
                if (cnt_reg == col_w) begin
                    cnt_next   = 12'd0;
                    state_next = S_KEX;
                end else begin
                    cnt_next = cnt_reg + 12'd1;
                end
            end
            S_KEX: begin
                inst_next[0] = 1'b1;
                inst_next[3] = 1'b1;
                if (cnt_reg == col_w - 12'd1) begin
                    cnt_next   = 12'd0;
                    state_next = S_GAP;
                end else begin
                    cnt_next = cnt_reg + 12'd1;
                end
            end
            S_GAP: begin
                if (cnt_reg == gap_w - 12'd1) begin
                    cnt_next   = 12'd0;
                    state_next = S_ALD;
                end else begin
                    cnt_next = cnt_reg + 12'd1;
                end
            end
            S_ALD: begin
                if (cnt_reg != n_ext) begin
                    inst_next[19]   = 1'b0;
                    inst_next[17:7] = xbase_reg + col_a + cnt_reg[10:0];
                end
                if (cnt_reg != 12'd0)
                    inst_next[2] = 1'b1;
                if (cnt_reg == n_ext) begin
                    cnt_next   = 12'd0;
                    state_next = S_EXE;
                end else begin
                    cnt_next = cnt_reg + 12'd1;
                end
            end
            S_EXE: begin
                inst_next[1] = 1'b1;
                inst_next[3] = 1'b1;
                if (cnt_reg == n_ext - 12'd1) begin
                    cnt_next   = 12'd0;
                    state_next = S_DRN;
                end else begin
                    cnt_next = cnt_reg + 12'd1;
                end
            end
            S_DRN: begin
                // The pmem write of row m may share the word with ofifo_rd of row m+1.
                if (pend_reg) begin
                    inst_next[32]    = 1'b0;
                    inst_next[31]    = 1'b0;
                    inst_next[30:20] = pbase_reg + wr_cnt_reg;
                    wr_cnt_next      = wr_cnt_reg + 11'd1;
                    if (wr_cnt_reg == n_act_reg - 11'd1)
                        state_next = S_DONE;
                end
                if (ofifo_valid && (rd_cnt_reg != n_act_reg)) begin
                    inst_next[6] = 1'b1;
                    rd_cnt_next  = rd_cnt_reg + 11'd1;
                    pend_next    = 1'b1;
                end
`ifdef SEQ_DRAIN_TIMEOUT_EN
                if (ofifo_valid) begin
                    to_cnt_next = 10'd0;
                end else if (to_cnt_reg == 10'd1022) begin
                    state_next = S_DONE;
                    err_next   = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + 10'd1;
                end
`endif
            end
            S_DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 12'd0;
            n_act_reg   <= 11'd0;
            xbase_reg   <= 11'd0;
            pbase_reg   <= 11'd0;
            rd_cnt_reg  <= 11'd0;
            wr_cnt_reg  <= 11'd0;
            pend_reg    <= 1'b0;
            inst_reg    <= idle_inst;
            dx_reg      <= '0;
            s_ready_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            n_act_reg   <= n_act_next;
            xbase_reg   <= xbase_next;
            pbase_reg   <= pbase_next;
            rd_cnt_reg  <= rd_cnt_next;
            wr_cnt_reg  <= wr_cnt_next;
            pend_reg    <= pend_next;
            inst_reg    <= inst_next;
            dx_reg      <= dx_next;
            s_ready_reg <= s_ready_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

`ifdef SEQ_DRAIN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg    <= 1'b0;
            to_cnt_reg <= 10'd0;
        end else begin
            err_reg    <= err_next;
            to_cnt_reg <= to_cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_ws_sequencer.sv
// tb_ws_sequencer: tiles checked every cycle against a phase-timeline model of the sequencer,
// plus literal checks of addresses, pulse counts and start-to-done latency.
module tb_ws_sequencer;
    localparam int bw = 4, row = 8, col = 8, gap_cyc = 16, dw = row * bw;
    // bits 32, 31, 19, 18 set
    localparam logic [34:0] idle_w = 35'h1_800C_0000;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, s_valid = 1'b0, ofifo_valid = 1'b0;
    logic [10:0]   n_act = '0, xmem_base = '0, pmem_base = '0;
    logic [dw-1:0] s_data = '0;
    logic          s_ready, busy, done, err;
    logic [34:0]   inst;
    logic [dw-1:0] D_xmem;

    int tests = 0, fails = 0, cyc = 0;

    ws_sequencer #(.bw(bw), .row(row), .col(col), .gap_cyc(gap_cyc)) dut (
        .clk(clk), .reset(reset), .start(start), .n_act(n_act),
        .xmem_base(xmem_base), .pmem_base(pmem_base),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ofifo_valid(ofifo_valid), .inst(inst), .D_xmem(D_xmem),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [34:0] xw_inst(input logic [10:0] a);
        logic [34:0] w;
        w = idle_w; w[19] = 1'b0; w[18] = 1'b0; w[17:7] = a;
        return w;
    endfunction

    function automatic logic [34:0] xr_inst(input logic [10:0] a);
        logic [34:0] w;
        w = idle_w; w[19] = 1'b0; w[17:7] = a;
        return w;
    endfunction

    // ---------------- reference model: fixed phase timeline after the last stream write
    bit            m_act = 0, m_wr = 0, m_pend = 0, m_fin = 0;
    int            m_k, m_n, m_tend, m_rd, m_wrc, m_zero;
    logic [10:0]   m_xb, m_pb;
    logic [34:0]   e_inst = idle_w;
    logic          e_ready = 0, e_busy = 0, e_done = 0, e_err = 0, e_xw = 0;
    logic [dw-1:0] e_dx = '0;

    always @(posedge clk) begin
        int d, t_kex, t_gap, t_ald, t_exe, t_drn, j;
        cyc++;
        e_inst = idle_w; e_done = 0; e_xw = 0;
        if (reset) begin
            m_act = 0; m_fin = 0; e_ready = 0; e_busy = 0; e_err = 0;
        end else if (!m_act) begin
            if (start) begin
                e_err = 0;
                if (n_act == 11'd0) e_done = 1;
                else begin
                    m_act = 1; m_wr = 1; m_fin = 0; m_k = 0; m_n = int'(n_act);
                    m_xb = xmem_base; m_pb = pmem_base; e_ready = 1; e_busy = 1;
                end
            end
        end else if (m_fin) begin
            e_done = 1; e_busy = 0; m_act = 0; m_fin = 0;
        end else if (m_wr) begin
            if (s_valid && e_ready) begin
                e_inst = xw_inst(m_xb + 11'(m_k)); e_xw = 1; e_dx = s_data; m_k++;
                if (m_k == col + m_n) begin
                    e_ready = 0; m_wr = 0; m_tend = cyc;
                    m_rd = 0; m_wrc = 0; m_pend = 0; m_zero = 0;
                end
            end
        end else begin
            d     = cyc - m_tend;
            t_kex = col + 1;
            t_gap = t_kex + col;
            t_ald = t_gap + gap_cyc;
            t_exe = t_ald + m_n + 1;
            t_drn = t_exe + m_n;
            if (d <= t_kex) begin
                if (d <= col) e_inst = xr_inst(m_xb + 11'(d - 1));
                if (d >= 2) e_inst[2] = 1'b1;
            end else if (d <= t_gap) begin
                e_inst[0] = 1'b1; e_inst[3] = 1'b1;
            end else if (d <= t_ald) begin
                e_inst = idle_w;
            end else if (d <= t_exe) begin
                j = d - t_ald - 1;
                if (j < m_n) e_inst = xr_inst(m_xb + 11'(col) + 11'(j));
                if (j >= 1) e_inst[2] = 1'b1;
            end else if (d <= t_drn) begin
                e_inst[1] = 1'b1; e_inst[3] = 1'b1;
            end else begin
                if (m_pend) begin
                    e_inst[32] = 1'b0; e_inst[31] = 1'b0; e_inst[30:20] = m_pb + 11'(m_wrc);
                    m_wrc++; m_pend = 0;
                    if (m_wrc == m_n) m_fin = 1;
                end
                if (ofifo_valid && m_rd < m_n) begin
                    e_inst[6] = 1'b1; m_rd++; m_pend = 1;
                end
`ifdef SEQ_DRAIN_TIMEOUT_EN
                if (ofifo_valid) m_zero = 0;
                else begin
                    m_zero++;
                    if (m_zero == 1023) begin m_fin = 1; e_err = 1; end
                end
`endif
            end
        end
    end

    // ---------------- every-cycle compare against the model
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("inst", 64'(inst), 64'(e_inst));
            chk("s_ready", 64'(s_ready), 64'(e_ready));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("err", 64'(err), 64'(e_err));
            if (e_xw) chk("D_xmem", 64'(D_xmem), 64'(e_dx));
        end
    end

    // ---------------- activity log for literal checks
    int   cen_n = 0, l0w_n = 0, ld_n = 0, ex_n = 0;
    int   xw_a[$], pw_a[$];

    always @(negedge clk) begin
        if (!inst[19] && !inst[18]) xw_a.push_back(int'(inst[17:7]));
        if (!inst[32] && !inst[31]) pw_a.push_back(int'(inst[30:20]));
        if (!inst[19] || !inst[32]) cen_n++;
        l0w_n += int'(inst[2]);
        ld_n  += int'(inst[0]);
        ex_n  += int'(inst[1]);
    end

    task automatic clr_logs();
        xw_a.delete(); pw_a.delete();
        cen_n = 0; l0w_n = 0; ld_n = 0; ex_n = 0;
    endtask

    // vmode: 0 s_valid high, 1 toggling, 2 random. omode: 0 high, 1 stuck low, 2 random.
    // spam: 0 none, 1 random start pulses, 2 start pulses in the execute window.
    task automatic run_tile(input int n, input int xb, input int pb, input int vmode,
                            input int omode, input int spam, input int abort_at, output int lat);
        clr_logs();
        n_act = 11'(n); xmem_base = 11'(xb); pmem_base = 11'(pb); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 0;
        while (!done && lat < 3000) begin
            s_data = $urandom;
            case (vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (lat % 2 == 0);
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            case (omode)
                0:       ofifo_valid = 1'b1;
                1:       ofifo_valid = 1'b0;
                default: ofifo_valid = ($urandom_range(0, 2) != 0);
            endcase
            start = ((spam == 1) && ($urandom_range(0, 5) == 0)) ||
                    ((spam == 2) && (lat >= 49) && (lat <= 54));
            if (start) begin
                n_act = 11'($urandom); xmem_base = 11'($urandom); pmem_base = 11'($urandom);
            end
            if (lat == abort_at) reset = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (reset) break;
        end
        start = 1'b0; s_valid = 1'b0;
        if (abort_at < 0) chk("tile_done_seen", 64'(done), 64'd1);
        $display("[TB] tile n_act=%0d xbase=%0d pbase=%0d cycles=%0d", n, xb, pb, lat);
    endtask

    initial begin
        int lat;
        int exp_x[10] = '{2044, 2045, 2046, 2047, 0, 1, 2, 3, 4, 5};

        // reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("reset_inst", 64'(inst), 64'(35'h1_800C_0000));
        chk("reset_s_ready", 64'(s_ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_D_xmem", 64'(D_xmem), 64'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // full tile with start pulses during execute
        run_tile(4, 0, 100, 0, 0, 2, -1, lat);
        chk("full_latency", 64'(lat), 64'd60);
        chk("full_xw_count", 64'(xw_a.size()), 64'd12);
        for (int i = 0; i < 12 && i < xw_a.size(); i++) chk("full_xw_addr", 64'(xw_a[i]), 64'(i));
        chk("full_l0wr_kernel_plus_act", 64'(l0w_n), 64'd12);
        chk("full_load_cycles", 64'(ld_n), 64'd8);
        chk("full_exec_cycles", 64'(ex_n), 64'd4);
        chk("full_pw_count", 64'(pw_a.size()), 64'd4);
        for (int i = 0; i < 4 && i < pw_a.size(); i++) chk("full_pw_addr", 64'(pw_a[i]), 64'(100 + i));
        repeat (2) @(posedge clk);
        #1;

        // back-pressure: s_valid toggling
        run_tile(3, 500, 7, 1, 0, 0, -1, lat);
        chk("bp_latency", 64'(lat), 64'd66);
        chk("bp_xw_count", 64'(xw_a.size()), 64'd11);
        for (int i = 0; i < 11 && i < xw_a.size(); i++) chk("bp_xw_addr", 64'(xw_a[i]), 64'(500 + i));
        repeat (2) @(posedge clk);
        #1;

        // address wrap
        run_tile(2, 2044, 2047, 0, 0, 0, -1, lat);
        chk("wrap_xw_count", 64'(xw_a.size()), 64'd10);
        for (int i = 0; i < 10 && i < xw_a.size(); i++) chk("wrap_xw_addr", 64'(xw_a[i]), 64'(exp_x[i]));
        chk("wrap_pw_count", 64'(pw_a.size()), 64'd2);
        if (pw_a.size() == 2) begin
            chk("wrap_pw_addr0", 64'(pw_a[0]), 64'd2047);
            chk("wrap_pw_addr1", 64'(pw_a[1]), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1;

        // n_act = 0: immediate done, no memory traffic
        clr_logs();
        n_act = 11'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("zero_done_cleared", 64'(done), 64'd0);
        chk("zero_no_cen", 64'(cen_n), 64'd0);
        $display("[TB] tile n_act=0 done next cycle");

        // reset while draining
        run_tile(4, 10, 20, 0, 1, 0, 70, lat);
        reset = 1'b0;
        chk("abort_inst", 64'(inst), 64'(35'h1_800C_0000));
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_s_ready", 64'(s_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;

`ifdef SEQ_DRAIN_TIMEOUT_EN
        run_tile(2, 30, 40, 0, 1, 0, -1, lat);
        chk("timeout_latency", 64'(lat), 64'd1072);
        chk("timeout_err", 64'(err), 64'd1);
        repeat (2) @(posedge clk);
        #1;
`endif

        // randomized tiles
        for (int t = 0; t < 25; t++) begin
            run_tile($urandom_range(1, 20), $urandom_range(0, 2047), $urandom_range(0, 2047),
                     2, 2, 1, -1, lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
